// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// Holds the FSM state encoding and the default framing parameters.
// No ports; import with uart_pkg::*.
package uart_pkg;

  // Encoding is fixed so that state values stay stable across rx and tx.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Ticks per bit period. Must be even and at least 4 so a mid-bit point exists.
  localparam int UART_OVERSAMPLE = 16;
  // Data bits per frame, sent LSB first.
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: two clock cycles from d to q. No backpressure.
// Ports: clock, reset_n (synchronous, active-low), d (async input), q (synchronized output).
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a one-deep output holding register.
// Latency: rx_done rises one clock after the stop-bit sample tick, plus two clocks of rx synchronization.
// Backpressure: none on the line; an unconsumed byte is overwritten and overrun pulses.
// Ports: clock, reset_n (sync, active-low), rx (async serial line), rx_tick (oversample strobe),
//        data_ack (consumer takes data_out), data_out, data_valid, rx_done, frame_error, overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rx_tick,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 rx_done,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Mid start bit: checking here re-centres sampling so data bits are taken mid-bit.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  uart_state_t          state,         state_n;
  logic [TW-1:0]        tick_cnt,      tick_cnt_n;
  logic [BW-1:0]        bit_cnt,       bit_cnt_n;
  logic [DATA_BITS-1:0] shift,         shift_n;
  logic [DATA_BITS-1:0] data_out_n;
  logic                 data_valid_n;
  logic                 rx_done_n;
  logic                 frame_error_n;
  logic                 overrun_n;

  always_comb begin
    state_n       = state;
    tick_cnt_n    = tick_cnt;
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    data_out_n    = data_out;
    // An ack consumes the held byte; a byte completing this cycle re-sets it below.
    data_valid_n  = data_valid && !data_ack;
    rx_done_n     = 1'b0;
    frame_error_n = 1'b0;
    overrun_n     = 1'b0;

    if (rx_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n    = START;
            tick_cnt_n = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            // Line back high at mid start bit means it was a glitch.
            state_n    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            // LSB arrives first, so shifting right leaves it at bit 0 after the last sample.
            shift_n    = {rx_s, shift[DATA_BITS-1:1]};
            tick_cnt_n = '0;
            bit_cnt_n  = bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
              state_n = STOP;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            state_n    = IDLE;
            tick_cnt_n = '0;
            if (rx_s) begin
              data_out_n   = shift;
              data_valid_n = 1'b1;
              rx_done_n    = 1'b1;
              // Acked in the same cycle means the old byte was taken, so nothing is lost.
              overrun_n    = data_valid && !data_ack;
            end else begin
              frame_error_n = 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      data_out    <= data_out_n;
      data_valid  <= data_valid_n;
      rx_done     <= rx_done_n;
      frame_error <= frame_error_n;
      overrun     <= overrun_n;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames, line-level model, per-cycle output comparison.
// Frames are driven 16 ticks per bit, aligned just after a tick edge; ticks every 4 clocks.
// Ports of the DUT are all driven/observed here.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS = 16;
  localparam int DB = 8;
  // Tick distance from the tick edge at which rx falls to the stop-bit sample:
  // detect 1 tick later (2-flop sync), start mid point 8 ticks on, then 9 bit periods of 16.
  localparam int STOP_SAMPLE_OFS = 1 + OS / 2 + (DB + 1) * OS;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_tick = 1'b0;
  logic          data_ack = 1'b0;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          rx_done;
  logic          frame_error;
  logic          overrun;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_tick     (rx_tick),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .rx_done     (rx_done),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            tick;
    bit            ok;
    logic [DB-1:0] dat;
  } ev_t;

  ev_t           evq[$];
  int            tick_no = 0;
  int            tdiv = 0;
  int            checks = 0;
  int            errors = 0;
  int            n_done = 0;
  int            n_ferr = 0;
  int            n_ovr = 0;
  logic [DB-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          e_done = 1'b0;
  logic          e_ferr = 1'b0;
  logic          e_ovr = 1'b0;
  bit            started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Oversampling strobe: one clock high out of every four.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      rx_tick = (tdiv == 0);
      tdiv = (tdiv + 1) % 4;
    end
  end

  // Model update on each rising edge, comparison half a cycle later.
  initial begin
    logic ack_s, tick_s, rst_s, fire;
    ev_t  ev;
    forever begin
      @(posedge clock);
      ack_s  = data_ack;
      tick_s = rx_tick;
      rst_s  = reset_n;
      if (tick_s) tick_no++;
      e_done = 1'b0;
      e_ferr = 1'b0;
      e_ovr  = 1'b0;
      if (!rst_s) begin
        m_data  = '0;
        m_valid = 1'b0;
        evq.delete();
        started = 1'b1;
      end else begin
        fire = 1'b0;
        if (tick_s && evq.size() > 0 && evq[0].tick == tick_no) begin
          ev   = evq.pop_front();
          fire = 1'b1;
        end
        if (fire && ev.ok) begin
          e_done  = 1'b1;
          e_ovr   = m_valid && !ack_s;
          m_data  = ev.dat;
          m_valid = 1'b1;
        end else begin
          if (fire) e_ferr = 1'b1;
          if (ack_s) m_valid = 1'b0;
        end
      end
      @(negedge clock);
      if (started) begin
        check("rx_done", rx_done, e_done);
        check("frame_error", frame_error, e_ferr);
        check("overrun", overrun, e_ovr);
        check("data_out", data_out, m_data);
        check("data_valid", data_valid, m_valid);
        if (rx_done) n_done++;
        if (frame_error) n_ferr++;
        if (overrun) n_ovr++;
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      while (!rx_tick) @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1; reset_n = 1'b0;
    @(posedge clock); #1; reset_n = 1'b1;
  endtask

  task automatic pulse_ack();
    @(posedge clock); #1; data_ack = 1'b1;
    @(posedge clock); #1; data_ack = 1'b0;
  endtask

  // rst_bit >= 0 pulses reset_n for one cycle in the middle of that data bit.
  task automatic send_frame(input logic [DB-1:0] b, input bit stop, input bit ack_done,
                            input int rst_bit, input int gap);
    ev_t ev;
    wait_ticks(1);
    ev.tick = tick_no + STOP_SAMPLE_OFS;
    ev.ok   = stop;
    ev.dat  = b;
    evq.push_back(ev);
    rx = 1'b0;
    wait_ticks(OS);
    for (int k = 0; k < DB; k++) begin
      rx = b[k];
      if (k == rst_bit) begin
        wait_ticks(OS / 2);
        do_reset();
        wait_ticks(OS / 2);
      end else begin
        wait_ticks(OS);
      end
    end
    rx = stop;
    wait_ticks(8);
    if (ack_done) begin
      // Land data_ack on the clock edge carrying the stop-sample tick.
      repeat (3) @(posedge clock);
      #1; data_ack = 1'b1;
      @(posedge clock);
      #1; data_ack = 1'b0;
    end else begin
      wait_ticks(1);
    end
    wait_ticks(7);
    rx = 1'b1;
    wait_ticks(gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, f0, o0;
    repeat (3) @(posedge clock);
    #1; reset_n = 1'b1;
    @(negedge clock);
    check("reset_data_out", data_out, 0);
    check("reset_data_valid", data_valid, 0);
    check("reset_rx_done", rx_done, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_overrun", overrun, 0);
    check("reset_state", dut.state, IDLE);

    // Clean frame 0xA5.
    c0 = n_done; f0 = n_ferr;
    send_frame(8'hA5, 1'b1, 1'b0, -1, 4);
    check("a5_done_count", n_done - c0, 1);
    check("a5_ferr_count", n_ferr - f0, 0);
    check("a5_data_out", data_out, 8'hA5);
    check("a5_data_valid", data_valid, 1);
    check("a5_model_data", m_data, 8'hA5);

    // Stop bit low after a fresh reset.
    do_reset();
    c0 = n_done; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, -1, 8);
    check("3c_ferr_count", n_ferr - f0, 1);
    check("3c_done_count", n_done - c0, 0);
    check("3c_data_out", data_out, 8'h00);
    check("3c_data_valid", data_valid, 0);
    check("3c_model_valid", m_valid, 0);

    // Three-tick glitch, then a real frame.
    c0 = n_done; f0 = n_ferr;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(12);
    check("glitch_state", dut.state, IDLE);
    check("glitch_done_count", n_done - c0, 0);
    check("glitch_ferr_count", n_ferr - f0, 0);
    send_frame(8'h5A, 1'b1, 1'b0, -1, 4);
    check("5a_data_out", data_out, 8'h5A);
    check("5a_done_count", n_done - c0, 1);

    // Back-to-back without ack: the second byte overruns.
    pulse_ack();
    @(negedge clock);
    check("ack_clears_valid", data_valid, 0);
    c0 = n_done; o0 = n_ovr;
    send_frame(8'h11, 1'b1, 1'b0, -1, 0);
    send_frame(8'h22, 1'b1, 1'b0, -1, 4);
    check("ovr_count", n_ovr - o0, 1);
    check("ovr_done_count", n_done - c0, 2);
    check("ovr_data_out", data_out, 8'h22);
    check("ovr_data_valid", data_valid, 1);

    // Same again with ack landing on the completion edge: no overrun.
    pulse_ack();
    o0 = n_ovr;
    send_frame(8'h11, 1'b1, 1'b0, -1, 0);
    send_frame(8'h22, 1'b1, 1'b1, -1, 4);
    check("ackdone_ovr_count", n_ovr - o0, 0);
    check("ackdone_data_out", data_out, 8'h22);
    check("ackdone_data_valid", data_valid, 1);

    // Reset in the middle of bit 4 of 0xFF abandons the frame.
    c0 = n_done; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'hFF, 1'b1, 1'b0, 4, 4);
    check("rst_done_count", n_done - c0, 0);
    check("rst_ferr_count", n_ferr - f0, 0);
    check("rst_ovr_count", n_ovr - o0, 0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 0);
    send_frame(8'h81, 1'b1, 1'b0, -1, 4);
    check("81_data_out", data_out, 8'h81);
    check("81_data_valid", data_valid, 1);

    // Zero byte, then ack, then a stray ack with nothing held.
    pulse_ack();
    send_frame(8'h00, 1'b1, 1'b0, -1, 4);
    check("00_data_valid", data_valid, 1);
    check("00_data_out", data_out, 8'h00);
    pulse_ack();
    @(negedge clock);
    check("00_ack_valid", data_valid, 0);
    pulse_ack();
    @(negedge clock);
    check("stray_ack_valid", data_valid, 0);
    check("stray_ack_data", data_out, 8'h00);
    check("model_final_valid", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
